pu_compare_sched: RTL and testbench

PU_COMPARE_SCHED -- requirements
Module: pu_compare_sched

---
 rtl/pu_compare_sched_pkg.sv | 23 ++
 rtl/pu_compare_sched_arb.sv | 30 +++
 rtl/pu_compare_sched_pu.sv | 70 +++++++
 rtl/pu_compare_sched.sv | 143 ++++++++++++++
 tb/tb_pu_compare_sched.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pu_compare_sched_pkg.sv
// Shared op-codes and scheduler state encodings for the compare scheduler and its PU.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pu_compare_sched_pkg;

    // Comparison op-codes understood by the comparator PU
    localparam int OP_EQ  = 0;
    localparam int OP_LT  = 1;
    localparam int OP_LTE = 2;
    localparam int OP_GT  = 3;
    localparam int OP_GTE = 4;

    // Scheduler FSM states
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_WR_A  = 3'd2,
        ST_WR_B  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_READ  = 3'd5
    } state_e;

endpackage

// File: rtl/pu_compare_sched_arb.sv
// Round-robin arbiter: one-hot grant, search starts just after the pointer.
// Latency: combinational.
// Backpressure: none; the caller decides when a grant is consumed.
module rr_arbiter #(
    parameter int REQ_NUM = 4,
    parameter int IDX_W   = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic [REQ_NUM-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [REQ_NUM-1:0] grant
);

    logic [IDX_W-1:0] idx;
    logic             found;

    // Walk requesters ptr+1, ptr+2, ... wrapping, and grant the first one set
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= REQ_NUM; i++) begin
            idx = IDX_W'((int'(ptr) + i) % REQ_NUM);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pu_compare_sched_pu.sv
// Comparator PU: takes a then b over two write strobes, compares them signed.
// Latency: result registered one cycle after the second write, read with oe.
// Backpressure: none; writes are always accepted, sync reset clears the argument index.
module pu_comparator
    import pu_compare_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ATTR_WIDTH = 4,
    parameter int SEL_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic                  oe,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ATTR_WIDTH-1:0] attr_in,
    input  logic [SEL_WIDTH-1:0]  op_sel,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic                  arg_idx;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [SEL_WIDTH-1:0]  op_q;
    logic                  res_q;
    logic                  cmp_res;

    // The comparator has no attribute-dependent mode; the port exists for PU interface compatibility
    logic unused_attr;
    assign unused_attr = ^attr_in;

    // Signed comparison of the stored operands; unknown op-codes yield 0
    always_comb begin
        cmp_res = 1'b0;
        case (op_q)
            SEL_WIDTH'(OP_EQ):  cmp_res = ($signed(a_q) == $signed(b_q));
            SEL_WIDTH'(OP_LT):  cmp_res = ($signed(a_q) <  $signed(b_q));
            SEL_WIDTH'(OP_LTE): cmp_res = ($signed(a_q) <= $signed(b_q));
            SEL_WIDTH'(OP_GT):  cmp_res = ($signed(a_q) >  $signed(b_q));
            SEL_WIDTH'(OP_GTE): cmp_res = ($signed(a_q) >= $signed(b_q));
            default:            cmp_res = 1'b0;
        endcase
    end

    // First write stores a and op, second stores b; result is re-registered every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            arg_idx <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= 1'b0;
        end else begin
            if (wr) begin
                if (!arg_idx) begin
                    a_q     <= data_in;
                    op_q    <= op_sel;
                    arg_idx <= 1'b1;
                end else begin
                    b_q     <= data_in;
                    arg_idx <= 1'b0;
                end
            end
            res_q <= cmp_res;
        end
    end

    assign data_out = oe ? {{(DATA_WIDTH-1){1'b0}}, res_q} : '0;

endmodule

// File: rtl/pu_compare_sched.sv
// Arbitrates REQ_NUM compare requesters onto one comparator PU, round-robin.
// Latency: ack one cycle after req is sampled in IDLE, resp_valid four cycles after ack.
// Backpressure: requesters hold req until ack; one comparison in flight, one per 5 cycles.
module pu_compare_sched
    import pu_compare_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ATTR_WIDTH = 4,
    parameter int SEL_WIDTH  = 3,
    parameter int REQ_NUM    = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [REQ_NUM-1:0]              req,
    input  logic [REQ_NUM*SEL_WIDTH-1:0]    req_op,
    input  logic [REQ_NUM*DATA_WIDTH-1:0]   req_a,
    input  logic [REQ_NUM*DATA_WIDTH-1:0]   req_b,
    output logic [REQ_NUM-1:0]              ack,
    output logic [REQ_NUM-1:0]              resp_valid,
    output logic                            resp_result,
    output logic                            busy,
    output logic                            pu_rst,
    output logic                            pu_wr,
    output logic                            pu_oe,
    output logic [DATA_WIDTH-1:0]           pu_data_in,
    output logic [ATTR_WIDTH-1:0]           pu_attr_in,
    output logic [SEL_WIDTH-1:0]            pu_op_sel,
    input  logic [DATA_WIDTH-1:0]           pu_data_out
);

    localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    state_e                state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [REQ_NUM-1:0]    grant;
    logic [REQ_NUM-1:0]    grant_q;
    logic [IDX_W-1:0]      grant_idx;
    logic [SEL_WIDTH-1:0]  sel_op;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic [DATA_WIDTH-1:0] b_q;

    // Only the outcome bit of the PU result is meaningful
    logic unused_dout;
    assign unused_dout = ^pu_data_out[DATA_WIDTH-1:1];

    assign pu_attr_in = '0;

    rr_arbiter #(
        .REQ_NUM (REQ_NUM),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Encode the one-hot grant and mux out that requester's op-code and operands
    always_comb begin
        grant_idx = '0;
        sel_op    = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
                sel_op    = req_op[i*SEL_WIDTH +: SEL_WIDTH];
                sel_a     = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                sel_b     = req_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Scheduler FSM; every output is set on the transition into the state that owns it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_INIT;
            rr_ptr      <= IDX_W'(REQ_NUM - 1);
            grant_q     <= '0;
            b_q         <= '0;
            ack         <= '0;
            resp_valid  <= '0;
            resp_result <= 1'b0;
            busy        <= 1'b1;
            pu_rst      <= 1'b1;
            pu_wr       <= 1'b0;
            pu_oe       <= 1'b0;
            pu_data_in  <= '0;
            pu_op_sel   <= '0;
        end else begin
            ack        <= '0;
            resp_valid <= '0;
            pu_rst     <= 1'b0;
            pu_wr      <= 1'b0;
            pu_oe      <= 1'b0;
            pu_data_in <= '0;
            case (state)
                ST_INIT: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (|req) begin
                        grant_q    <= grant;
                        rr_ptr     <= grant_idx;
                        b_q        <= sel_b;
                        ack        <= grant;
                        pu_wr      <= 1'b1;
                        pu_data_in <= sel_a;
                        pu_op_sel  <= sel_op;
                        busy       <= 1'b1;
                        state      <= ST_WR_A;
                    end
                end
                ST_WR_A: begin
                    pu_wr      <= 1'b1;
                    pu_data_in <= b_q;
                    state      <= ST_WR_B;
                end
                ST_WR_B: begin
                    // Idle cycle on the PU bus while it registers the comparison
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    pu_oe <= 1'b1;
                    state <= ST_READ;
                end
                ST_READ: begin
                    resp_valid  <= grant_q;
                    resp_result <= pu_data_out[0];
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    pu_rst <= 1'b1;
                    busy   <= 1'b1;
                    state  <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pu_compare_sched.sv
module tb_pu_compare_sched;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int SW = 3;
    localparam int RN = 4;

    logic              clk;
    logic              rst;
    logic [RN-1:0]     req;
    logic [RN*SW-1:0]  req_op;
    logic [RN*DW-1:0]  req_a;
    logic [RN*DW-1:0]  req_b;
    logic [RN-1:0]     ack;
    logic [RN-1:0]     resp_valid;
    logic              resp_result;
    logic              busy;
    logic              pu_rst;
    logic              pu_wr;
    logic              pu_oe;
    logic [DW-1:0]     pu_data_in;
    logic [AW-1:0]     pu_attr_in;
    logic [SW-1:0]     pu_op_sel;
    logic [DW-1:0]     pu_data_out;

    typedef struct packed {
        logic [RN-1:0] vld;
        logic          res;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_exp;
    int   checks = 0;
    int   errors = 0;

    pu_compare_sched #(
        .DATA_WIDTH (DW),
        .ATTR_WIDTH (AW),
        .SEL_WIDTH  (SW),
        .REQ_NUM    (RN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .ack         (ack),
        .resp_valid  (resp_valid),
        .resp_result (resp_result),
        .busy        (busy),
        .pu_rst      (pu_rst),
        .pu_wr       (pu_wr),
        .pu_oe       (pu_oe),
        .pu_data_in  (pu_data_in),
        .pu_attr_in  (pu_attr_in),
        .pu_op_sel   (pu_op_sel),
        .pu_data_out (pu_data_out)
    );

    pu_comparator #(
        .DATA_WIDTH (DW),
        .ATTR_WIDTH (AW),
        .SEL_WIDTH  (SW)
    ) u_pu (
        .clk      (clk),
        .rst      (pu_rst),
        .wr       (pu_wr),
        .oe       (pu_oe),
        .data_in  (pu_data_in),
        .attr_in  (pu_attr_in),
        .op_sel   (pu_op_sel),
        .data_out (pu_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard pop on every response, plus PU bus invariants every cycle
    always @(negedge clk) begin
        if (rst) begin
            if (|resp_valid) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: resp_valid=%b result=%b, required no response", resp_valid, resp_result);
                end else begin
                    mon_exp = sb_q.pop_front();
                    if (resp_valid !== mon_exp.vld || resp_result !== mon_exp.res) begin
                        errors++;
                        $display("FAIL resp_data: got vld=%b res=%b, required vld=%b res=%b",
                                 resp_valid, resp_result, mon_exp.vld, mon_exp.res);
                    end
                end
            end
            checks++;
            if ($countones({pu_wr, pu_oe, pu_rst}) > 1) begin
                errors++;
                $display("FAIL pu_strobe_excl: wr=%b oe=%b rst=%b, required at most one high", pu_wr, pu_oe, pu_rst);
            end
            checks++;
            if (!pu_wr && pu_data_in !== '0) begin
                errors++;
                $display("FAIL pu_data_idle: pu_data_in=%h, required 0 when not writing", pu_data_in);
            end
        end
    end

    task automatic set_op(input int i, input logic [SW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_op[i*SW +: SW] = op;
        req_a[i*DW +: DW]  = a;
        req_b[i*DW +: DW]  = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        req    = '0;
        req_op = '0;
        req_a  = '0;
        req_b  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, pu_rst, pu_wr, pu_oe} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_ctrl: busy,pu_rst,pu_wr,pu_oe=%b, required 1100", {busy, pu_rst, pu_wr, pu_oe});
        end
        checks++;
        if (ack !== '0 || resp_valid !== '0 || resp_result !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp: ack=%b resp_valid=%b resp_result=%b, required all 0", ack, resp_valid, resp_result);
        end
        checks++;
        if (pu_data_in !== '0 || pu_op_sel !== '0 || pu_attr_in !== '0) begin
            errors++;
            $display("FAIL reset_pu_bus: data=%h op=%h attr=%h, required 0", pu_data_in, pu_op_sel, pu_attr_in);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (pu_rst !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL init_state: pu_rst=%b busy=%b, required 1 1", pu_rst, busy);
        end
        @(negedge clk);
        checks++;
        if (pu_rst !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_init: pu_rst=%b busy=%b, required 0 0", pu_rst, busy);
        end
    endtask

    task automatic test_single();
        int resp_k = 0;
        @(negedge clk);
        set_op(0, 3'd1, -32'sd5, 32'sd3);
        req = 4'b0001;
        sb_q.push_back('{vld: 4'b0001, res: 1'b1});
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (ack !== 4'b0001 || pu_wr !== 1'b1 || pu_data_in !== 32'hFFFF_FFFB || pu_op_sel !== 3'd1) begin
                    errors++;
                    $display("FAIL single_wr_a: ack=%b wr=%b data=%h op=%0d, required 0001 1 fffffffb 1",
                             ack, pu_wr, pu_data_in, pu_op_sel);
                end
                req = '0;
            end
            if (k == 2) begin
                checks++;
                if (pu_wr !== 1'b1 || pu_data_in !== 32'd3 || pu_op_sel !== 3'd1) begin
                    errors++;
                    $display("FAIL single_wr_b: wr=%b data=%h op=%0d, required 1 3 1", pu_wr, pu_data_in, pu_op_sel);
                end
            end
            if (k == 4) begin
                checks++;
                if (pu_oe !== 1'b1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL single_read: oe=%b busy=%b, required 1 1", pu_oe, busy);
                end
            end
            if (|resp_valid && resp_k == 0) resp_k = k;
        end
        checks++;
        if (resp_k != 5) begin
            errors++;
            $display("FAIL single_latency: resp at +%0d, required +5", resp_k);
        end
    endtask

    task automatic test_back_to_back();
        int first_k  = 0;
        int second_k = 0;
        @(negedge clk);
        set_op(2, 3'd0, 32'd7, 32'd7);
        req = 4'b0100;
        sb_q.push_back('{vld: 4'b0100, res: 1'b1});
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (ack !== 4'b0100) begin
                    errors++;
                    $display("FAIL b2b_ack1: ack=%b, required 0100", ack);
                end
                // New operands while the first comparison is in flight
                set_op(2, 3'd3, 32'd2, 32'd9);
                sb_q.push_back('{vld: 4'b0100, res: 1'b0});
            end
            if (k == 6) begin
                checks++;
                if (ack !== 4'b0100) begin
                    errors++;
                    $display("FAIL b2b_ack2: ack=%b, required 0100", ack);
                end
                req = '0;
            end
            if (|resp_valid) begin
                if (first_k == 0) first_k = k;
                else if (second_k == 0) second_k = k;
            end
        end
        checks++;
        if (first_k != 5 || second_k != 10) begin
            errors++;
            $display("FAIL b2b_timing: resp at +%0d and +%0d, required +5 and +10", first_k, second_k);
        end
    endtask

    task automatic test_round_robin();
        logic [RN-1:0] ord [5];
        int            n = 0;
        ord[0] = 4'b0001;
        ord[1] = 4'b0010;
        ord[2] = 4'b0100;
        ord[3] = 4'b1000;
        ord[4] = 4'b0001;
        do_reset();
        for (int i = 0; i < RN; i++) set_op(i, 3'd4, 32'd0, 32'd0);
        req = 4'b1111;
        for (int j = 0; j < 5; j++) sb_q.push_back('{vld: ord[j], res: 1'b1});
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            if (|ack) begin
                checks++;
                if (n >= 5 || ack !== ord[n]) begin
                    errors++;
                    $display("FAIL rr_order: grant %0d ack=%b, required %b", n, ack, (n < 5) ? ord[n] : 4'b0000);
                end
                n++;
            end
            if (k == 21) req = '0;
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL rr_count: %0d grants, required 5", n);
        end
    endtask

    task automatic test_reset_abort();
        int stray  = 0;
        int resp_k = 0;
        @(negedge clk);
        set_op(1, 3'd1, 32'd0, 32'd5);
        req = 4'b0010;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) req = '0;
            if (k == 3) begin
                checks++;
                if (pu_wr !== 1'b0 || pu_oe !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_wait: wr=%b oe=%b busy=%b, required 0 0 1", pu_wr, pu_oe, busy);
                end
                rst = 1'b0;
            end
            if (k == 4) begin
                checks++;
                if (pu_rst !== 1'b1 || resp_valid !== '0) begin
                    errors++;
                    $display("FAIL abort_in_reset: pu_rst=%b resp_valid=%b, required 1 0000", pu_rst, resp_valid);
                end
                rst = 1'b1;
            end
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (|resp_valid || |ack) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL abort_silent: %0d cycles with ack/resp, required 0", stray);
        end
        set_op(1, 3'd2, 32'd1, 32'd1);
        req = 4'b0010;
        sb_q.push_back('{vld: 4'b0010, res: 1'b1});
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) req = '0;
            if (|resp_valid && resp_k == 0) resp_k = k;
        end
        checks++;
        if (resp_k != 5) begin
            errors++;
            $display("FAIL abort_recover: resp at +%0d, required +5", resp_k);
        end
    endtask

    task automatic test_bad_op();
        int resp_k = 0;
        @(negedge clk);
        set_op(3, 3'd6, 32'd1, 32'd1);
        req = 4'b1000;
        sb_q.push_back('{vld: 4'b1000, res: 1'b0});
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (pu_op_sel !== 3'd6) begin
                    errors++;
                    $display("FAIL bad_op_fwd: pu_op_sel=%0d, required 6", pu_op_sel);
                end
                req = '0;
            end
            if (|resp_valid && resp_k == 0) resp_k = k;
        end
        checks++;
        if (resp_k != 5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_op_done: resp at +%0d busy=%b, required +5 0", resp_k, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_round_robin();
        test_reset_abort();
        test_bad_op();
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d responses outstanding, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
